bts_led_pio_blink: RTL and testbench

Parametrised Avalon-MM output PIO driving board LEDs in the board test system, with per-bit blink capability. It replaces fixed 4-bit LED PIO slaves: width, reset value and blink-counter size are parameters, and atomic set/clear registers let software change one LED without a read-modify-write. It sits on the general Qsys interconnect as a zero-wait-state slave, with `out_port` wired to the LED pins.

---
 rtl/bts_led_pio_blink.sv | 85 ++++++++
 tb/tb_bts_led_pio_blink.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bts_led_pio_blink.sv
// bts_led_pio_blink: Avalon-MM LED output PIO with set/clear registers and optional per-bit blink.
// Blink engine (MODE/PERIOD registers) is built only when BTS_LED_PIO_BLINK_EN is defined.
module bts_led_pio_blink #(
  parameter int WIDTH = 4,
  parameter int PERIOD_W = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);
  logic             w_wr;
  logic             w_unused;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_gate;
  logic [WIDTH-1:0] r_data;
  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[WIDTH-1:0];
  assign w_unused = ^writedata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      out_port <= RESET_VALUE;
    end else begin
      r_data   <= !w_wr ? r_data :
                  address == 3'd0 ? w_wd :
                  address == 3'd3 ? r_data | w_wd :
                  address == 3'd4 ? r_data & ~w_wd : r_data;
      out_port <= r_data & w_gate;
    end
`ifdef BTS_LED_PIO_BLINK_EN
  logic [WIDTH-1:0]    r_mode;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_ph;
  // a PERIOD write restarts the blink cycle in the high phase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_mode   <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_ph     <= 1'b1;
    end else begin
      if (w_wr && address == 3'd1) r_mode <= w_wd;
      if (w_wr && address == 3'd2) begin
        r_period <= writedata[PERIOD_W-1:0];
        r_cnt    <= writedata[PERIOD_W-1:0];
        r_ph     <= 1'b1;
      end else if (r_period == '0) begin
        r_cnt <= '0;
        r_ph  <= 1'b1;
      end else if (r_cnt == '0) begin
        r_cnt <= r_period;
        r_ph  <= ~r_ph;
      end else
        r_cnt <= r_cnt - PERIOD_W'(1);
    end
  assign w_gate = ~r_mode | {WIDTH{r_ph}};
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(r_data);
      3'd1: readdata = 32'(r_mode);
      3'd2: readdata = 32'(r_period);
      3'd5: readdata = 32'(out_port);
      default: readdata = '0;
    endcase
  end
`else
  assign w_gate = '1;
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(r_data);
      3'd5: readdata = 32'(out_port);
      default: readdata = '0;
    endcase
  end
`endif
endmodule

// File: tb/tb_bts_led_pio_blink.sv
// tb_bts_led_pio_blink: scoreboarded random/directed bench with a time-based blink reference model.
module tb_bts_led_pio_blink;
  localparam int W = 4;
  localparam int PW = 4;
  localparam logic [3:0] RV = 4'hA;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [3:0] out_port;
  logic cs2 = 0, wn2 = 1;
  logic [2:0] a2 = 0;
  logic [31:0] wd2 = 0, rd2, o2;
  typedef struct packed {logic [3:0] out; logic chk; logic [2:0] a; logic [31:0] rd;} exp_t;
  exp_t q[$];
  exp_t me;
  int n_chk = 0, n_fail = 0;
  logic [3:0] m_data, m_mode, m_out, m_per;
  int m_t;

  bts_led_pio_blink #(.WIDTH(W), .PERIOD_W(PW), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port));
  bts_led_pio_blink #(.WIDTH(32), .PERIOD_W(8), .RESET_VALUE(32'h0)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(a2), .chipselect(cs2),
    .write_n(wn2), .writedata(wd2), .readdata(rd2), .out_port(o2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("out_port", 32'(out_port), 32'(me.out));
      if (me.chk) chk($sformatf("readdata[a=%0d]", me.a), readdata, me.rd);
    end

  // phase from elapsed edges since the last PERIOD write: high for PERIOD+1 edges, then low
  function automatic logic m_ph();
    return m_per == 0 || ((m_t / (int'(m_per) + 1)) % 2 == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    return a == 0 ? 32'(m_data) : a == 1 ? 32'(m_mode) : a == 2 ? 32'(m_per) :
           a == 5 ? 32'(m_out) : 32'h0;
  endfunction

  task automatic m_reset();
    m_data = RV; m_mode = 0; m_per = 0; m_t = 0; m_out = RV;
  endtask

  task automatic m_step(input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic [3:0] nout;
    nout = m_data & (~m_mode | {4{m_ph()}});
    m_t++;
    if (wr) begin
      if (a == 0) m_data = wd[3:0];
      if (a == 3) m_data = m_data | wd[3:0];
      if (a == 4) m_data = m_data & ~wd[3:0];
`ifdef BTS_LED_PIO_BLINK_EN
      if (a == 1) m_mode = wd[3:0];
      if (a == 2) begin m_per = wd[3:0]; m_t = 0; end
`endif
    end
    m_out = nout;
  endtask

  task automatic cyc(input bit rst, input logic cs, input logic wn, input logic [2:0] a,
                     input logic [31:0] wd, input bit c);
    exp_t e;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    if (rst) begin
      reset_n = 0;
      m_reset();
      #1 chk("reset_async", 32'(out_port), 32'(RV));
    end else reset_n = 1;
    e.out = m_out; e.chk = c; e.a = a; e.rd = m_read(a);
    q.push_back(e);
    @(posedge clk); #1;
    if (!rst) m_step(cs && !wn, a, wd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(0, 1, 0, a, d, 0);
  endtask
  task automatic rd(input logic [2:0] a);
    cyc(0, 1, 1, a, 0, 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 3'd5, 0, 1);
  endtask

  initial begin
    int r;
    logic [2:0] a;
    logic [31:0] d;
    m_reset();
    @(posedge clk); #1;
    cyc(1, 0, 1, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 1);
    rd(0);
    wr(0, 5); idle(2);
    wr(0, 3); wr(3, 32'hC); rd(0); wr(4, 1); rd(0); rd(3); rd(4);
    wr(3, 0); wr(4, 0); rd(0); wr(3, 32'hFFFF_FFFF); rd(0);
    wr(0, 32'hF); wr(1, 1); wr(2, 3); idle(14); wr(2, 0); idle(3);
    wr(2, 5); idle(5); wr(2, 5); idle(14);
    wr(1, 32'hF); wr(2, 2); idle(4);
    cyc(1, 0, 1, 3'd1, 0, 1); cyc(1, 0, 1, 3'd2, 0, 1);
    rd(1); rd(2); rd(0); idle(2);
    wr(0, 32'hF); wr(1, 32'h5); wr(2, 32'hF); idle(34);
    wr(6, 32'hFF); rd(6); rd(7);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 2) begin
        case ($urandom_range(0, 3))
          0: d = $urandom;
          1: d = 32'hF;
          default: d = $urandom_range(0, 5);
        endcase
      end
      if (r == 0) cyc(1, 0, 1, a, 0, 1);
      else if (r < 45) wr(a, d);
      else if (r < 75) rd(a);
      else if (r < 80) cyc(0, 0, 0, a, d, 1);
      else idle(1);
    end
    idle(1);
    chipselect = 0; write_n = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("scoreboard_drain", q.size(), 0);
    cs2 = 1; wn2 = 0; a2 = 0; wd2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    wn2 = 1;
    chk("w32_data_read", rd2, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("w32_out_port", o2, 32'hFFFF_FFFF);
    a2 = 5; #1 chk("w32_status", rd2, 32'hFFFF_FFFF);
    wn2 = 0; a2 = 1; wd2 = 7;
    @(posedge clk); #1;
    wn2 = 1;
`ifdef BTS_LED_PIO_BLINK_EN
    chk("w32_mode_read", rd2, 32'h7);
`else
    chk("w32_addr1_read", rd2, 32'h0);
`endif
    cs2 = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
